// File: rtl/core_pkg.sv
// Shared definitions for the two-stage fetch/execute core: opcodes,
// instruction field positions and the execute-stage state encoding.
package core_pkg;

  localparam int INST_WIDTH = 32;
  localparam int OP_WIDTH   = 4;
  localparam int IMM_WIDTH  = 13;

  // Instruction field positions (LSB of each field)
  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 23;
  localparam int RS1_LSB = 18;
  localparam int RS2_LSB = 13;
  localparam int IMM_LSB = 0;

  localparam logic [OP_WIDTH-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_ADD   = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_SUB   = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_AND   = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_OR    = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_LOAD  = 4'd5;
  localparam logic [OP_WIDTH-1:0] OP_STORE = 4'd6;
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = 4'd7;
  localparam logic [OP_WIDTH-1:0] OP_HALT  = 4'd8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_e;

  // Register-to-register ALU operations that write rd
  function automatic logic is_alu_op(input logic [OP_WIDTH-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction

  // Operations that go through the data-memory handshake
  function automatic logic is_mem_op(input logic [OP_WIDTH-1:0] op);
    return op inside {OP_LOAD, OP_STORE};
  endfunction

endpackage

// File: rtl/pipelined_core_if.sv
// Instruction-fetch and data-memory bus between the core (master) and the
// external memories (slave).
interface pipelined_core_if
  import core_pkg::*;
#(
  parameter int PC_WIDTH    = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int DADDR_WIDTH = 5
);

  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INST_WIDTH-1:0]  imem_data;
  logic                   dmem_req;
  logic                   dmem_we;
  logic [DADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0]  dmem_wdata;
  logic                   dmem_ack;
  logic [DATA_WIDTH-1:0]  dmem_rdata;

  modport master (
    output imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_data, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_data, dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/core_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// Register 0 is never written and always reads as zero.
module core_regfile #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] i_raddr_a,
  output logic [DATA_WIDTH-1:0]     o_rdata_a,
  input  logic [REG_ADDR_WIDTH-1:0] i_raddr_b,
  output logic [DATA_WIDTH-1:0]     o_rdata_b,
  input  logic                      i_we,
  input  logic [REG_ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]     i_wdata
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  // Clear all registers on reset; write rd on the execute edge, never r0
  // NOTE: this array is cleared by reset because the architecture promises
  // zeroed registers, so it maps to flops rather than a RAM macro.
  // NOTE: state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/pipelined_core.sv
// Two-stage fetch/execute core. Fetch latches one instruction per cycle;
// execute decodes it, runs the ALU or branch, or launches a data-memory
// access and stalls in MEM_WAIT until the memory acknowledges.
module pipelined_core
  import core_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PC_WIDTH       = 5,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DADDR_WIDTH    = 5,
  parameter int RETIRE_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_core_if.master        bus,
  output logic                    halted,
  output logic [RETIRE_WIDTH-1:0] retired
);

  // Architectural and pipeline state
  state_e                  r_state;
  logic [PC_WIDTH-1:0]     r_pc;
  logic [PC_WIDTH-1:0]     r_if_pc;
  logic [INST_WIDTH-1:0]   r_if_inst;
  logic                    r_if_valid;
  logic                    r_dmem_req;
  logic                    r_dmem_we;
  logic [DADDR_WIDTH-1:0]  r_dmem_addr;
  logic [DATA_WIDTH-1:0]   r_dmem_wdata;
  logic                    r_halted;
  logic [RETIRE_WIDTH-1:0] r_retired;

  // Decoded fields of the instruction in execute
  logic [OP_WIDTH-1:0]       w_op;
  logic [REG_ADDR_WIDTH-1:0] w_rd;
  logic [REG_ADDR_WIDTH-1:0] w_rs1;
  logic [REG_ADDR_WIDTH-1:0] w_rs2;
  logic [IMM_WIDTH-1:0]      w_imm;

  assign w_op  = r_if_inst[OP_LSB  +: OP_WIDTH];
  assign w_rd  = r_if_inst[RD_LSB  +: REG_ADDR_WIDTH];
  assign w_rs1 = r_if_inst[RS1_LSB +: REG_ADDR_WIDTH];
  assign w_rs2 = r_if_inst[RS2_LSB +: REG_ADDR_WIDTH];
  assign w_imm = r_if_inst[IMM_LSB +: IMM_WIDTH];

  // Register file read data and write-back controls
  logic [DATA_WIDTH-1:0]     w_rs1_val;
  logic [DATA_WIDTH-1:0]     w_rs2_val;
  logic                      w_rf_we;
  logic [REG_ADDR_WIDTH-1:0] w_rf_waddr;
  logic [DATA_WIDTH-1:0]     w_rf_wdata;

  core_regfile #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raddr_a (w_rs1),
    .o_rdata_a (w_rs1_val),
    .i_raddr_b (w_rs2),
    .o_rdata_b (w_rs2_val),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata)
  );

  // Sign-extended immediate arithmetic, truncated to the target width
  logic [DADDR_WIDTH-1:0] w_mem_addr;
  logic [PC_WIDTH-1:0]    w_branch_pc;
  logic                   w_branch_taken;
  logic                   w_exec;
  logic                   w_ack;

  assign w_mem_addr     = DADDR_WIDTH'(w_rs1_val) + DADDR_WIDTH'($signed(w_imm));
  assign w_branch_pc    = r_if_pc + PC_WIDTH'($signed(w_imm));
  assign w_branch_taken = (w_op == OP_BEQ) && (w_rs1_val == w_rs2_val);
  assign w_exec         = (r_state == RUN) && r_if_valid;
  assign w_ack          = (r_state == MEM_WAIT) && bus.dmem_ack;

  // ALU: modulo 2^DATA_WIDTH, no flags
  logic [DATA_WIDTH-1:0] w_alu;

  // Combinational ALU result for the instruction in execute
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_NOP:  w_alu = '0;
      OP_ADD:  w_alu = w_rs1_val + w_rs2_val;
      OP_SUB:  w_alu = w_rs1_val - w_rs2_val;
      OP_AND:  w_alu = w_rs1_val & w_rs2_val;
      OP_OR:   w_alu = w_rs1_val | w_rs2_val;
      default: w_alu = '0;
    endcase
  end

  // Write-back select: ALU result on execute, load data on the ack edge
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rd;
    w_rf_wdata = w_alu;
    if (w_exec && is_alu_op(w_op)) begin
      w_rf_we = 1'b1;
    end else if (w_ack && !r_dmem_we) begin
      w_rf_we    = 1'b1;
      w_rf_wdata = bus.dmem_rdata;
    end
  end

  // Fetch/execute control FSM with registered memory-bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_pc         <= '0;
      r_if_pc      <= '0;
      r_if_inst    <= '0;
      r_if_valid   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_halted     <= 1'b0;
      r_retired    <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (r_if_valid && is_mem_op(w_op)) begin
            // Launch the access; pc and the fetched instruction hold
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= (w_op == OP_STORE);
            r_dmem_addr  <= w_mem_addr;
            r_dmem_wdata <= w_rs2_val;
            r_state      <= MEM_WAIT;
          end else if (r_if_valid && (w_op == OP_HALT)) begin
            r_state   <= HALTED;
            r_halted  <= 1'b1;
            r_retired <= r_retired + RETIRE_WIDTH'(1);
          end else begin
            if (r_if_valid) begin
              r_retired <= r_retired + RETIRE_WIDTH'(1);
            end
            if (r_if_valid && w_branch_taken) begin
              // Redirect and squash the instruction fetched alongside
              r_pc       <= w_branch_pc;
              r_if_valid <= 1'b0;
            end else begin
              r_if_inst  <= bus.imem_data;
              r_if_pc    <= r_pc;
              r_if_valid <= 1'b1;
              r_pc       <= r_pc + PC_WIDTH'(1);
            end
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ack) begin
            // Memory op complete; fetch restarts from the held pc
            r_dmem_req <= 1'b0;
            r_state    <= RUN;
            r_if_valid <= 1'b0;
            r_retired  <= r_retired + RETIRE_WIDTH'(1);
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign bus.imem_addr  = r_pc;
  assign bus.dmem_req   = r_dmem_req;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign halted         = r_halted;
  assign retired        = r_retired;

endmodule

// File: tb/tb_pipelined_core.sv
// Directed bench for pipelined_core: fetch/wrap, delayed and immediate
// memory handshakes, branch flush, r0 and overflow behaviour, HALT and
// asynchronous reset during a pending access.
module tb_pipelined_core;
  import core_pkg::*;

  localparam int DATA_WIDTH     = 8;
  localparam int PC_WIDTH       = 5;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int DADDR_WIDTH    = 5;
  localparam int RETIRE_WIDTH   = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    halted;
  logic [RETIRE_WIDTH-1:0] retired;

  pipelined_core_if #(
    .PC_WIDTH    (PC_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .DADDR_WIDTH (DADDR_WIDTH)
  ) bus ();

  pipelined_core #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PC_WIDTH       (PC_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .DADDR_WIDTH    (DADDR_WIDTH),
    .RETIRE_WIDTH   (RETIRE_WIDTH)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  // Instruction memory: combinational read at the fetch address
  logic [31:0] imem [32];
  assign bus.imem_data = imem[bus.imem_addr];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    enc = {op, 5'(rd), 5'(rs1), 5'(rs2), 13'(imm)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_req(input string tag, input logic we, input int addr, input int wdata);
    check({tag, " req"},   {31'd0, bus.dmem_req}, 32'd1);
    check({tag, " we"},    {31'd0, bus.dmem_we},  {31'd0, we});
    check({tag, " addr"},  32'(bus.dmem_addr),    32'(addr));
    check({tag, " wdata"}, 32'(bus.dmem_wdata),   32'(wdata));
  endtask

  task automatic load_program();
    for (int i = 0; i < 32; i++) imem[i] = 32'd0;
    imem[0]  = enc(OP_LOAD,  2, 0, 0, 3);    // r2 = mem[3]
    imem[1]  = enc(OP_LOAD,  3, 0, 0, 4);    // r3 = mem[4]
    imem[2]  = enc(OP_LOAD,  4, 0, 0, 5);    // r4 = mem[5]
    imem[3]  = enc(OP_ADD,   5, 3, 4, 0);    // r5 = r3 + r4
    imem[4]  = enc(OP_ADD,   6, 6, 2, 0);    // r6 = r6 + r2
    imem[5]  = enc(OP_ADD,   0, 4, 4, 0);    // r0 write discarded
    imem[6]  = enc(OP_BEQ,   0, 6, 2, -2);   // to pc 4 while r6 == r2
    imem[7]  = enc(OP_STORE, 0, 0, 6, -1);   // mem[31] = r6
    imem[8]  = enc(OP_STORE, 0, 0, 5, 7);    // mem[7]  = r5
    imem[9]  = enc(OP_STORE, 0, 2, 0, 1);    // mem[r2+1] = r0
    imem[10] = enc(OP_HALT,  0, 0, 0, 0);
    imem[11] = enc(OP_ADD,   1, 2, 2, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // ---------------- Phase A: reset values, sequential fetch, pc wrap
    bus.dmem_ack   = 1'b1;   // spurious ack with no request must be ignored
    bus.dmem_rdata = 8'h5A;
    for (int i = 0; i < 32; i++) imem[i] = 32'd0;
    imem[0] = enc(OP_ADD, 1, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    check("rst pc",      32'(bus.imem_addr),  32'd0);
    check("rst req",     {31'd0, bus.dmem_req}, 32'd0);
    check("rst we",      {31'd0, bus.dmem_we},  32'd0);
    check("rst addr",    32'(bus.dmem_addr),  32'd0);
    check("rst wdata",   32'(bus.dmem_wdata), 32'd0);
    check("rst halted",  {31'd0, halted},     32'd0);
    check("rst retired", 32'(retired),        32'd0);
    release_reset();
    for (int k = 1; k <= 34; k++) begin
      tick();
      check($sformatf("A pc e%0d", k),      32'(bus.imem_addr), 32'(k % 32));
      check($sformatf("A retired e%0d", k), 32'(retired),       32'(k - 1));
    end
    check("A req idle", {31'd0, bus.dmem_req}, 32'd0);

    // ---------------- Phase B: memory handshakes, branch flush, HALT
    rst_n = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 8'h00;
    load_program();
    #1;
    check("B rst retired", 32'(retired), 32'd0);
    release_reset();

    tick();                                          // e1: fetch LOAD r2
    check("B pc e1", 32'(bus.imem_addr), 32'd1);
    tick();                                          // e2: LOAD issues
    check_req("ld r2", 1'b0, 3, 0);
    check("ld r2 pc frozen", 32'(bus.imem_addr), 32'd1);
    check("ld r2 retired", 32'(retired), 32'd0);
    tick();                                          // e3: waiting
    check("ld r2 wait1 req", {31'd0, bus.dmem_req}, 32'd1);
    check("ld r2 wait1 pc",  32'(bus.imem_addr),    32'd1);
    tick();                                          // e4: waiting
    check("ld r2 wait2 req", {31'd0, bus.dmem_req}, 32'd1);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 8'hA5;
    tick();                                          // e5: ack edge
    bus.dmem_ack = 1'b0;
    check("ld r2 done req", {31'd0, bus.dmem_req}, 32'd0);
    check("ld r2 retired+1", 32'(retired), 32'd1);
    check("ld r2 pc", 32'(bus.imem_addr), 32'd1);

    tick();                                          // e6: fetch LOAD r3
    tick();                                          // e7: LOAD r3 issues
    check_req("ld r3", 1'b0, 4, 0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 8'hFF;
    tick();                                          // e8: immediate ack
    bus.dmem_ack = 1'b0;
    check("ld r3 retired", 32'(retired), 32'd2);
    tick();                                          // e9
    tick();                                          // e10: LOAD r4 issues
    check_req("ld r4", 1'b0, 5, 0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 8'h02;
    tick();                                          // e11
    bus.dmem_ack = 1'b0;
    check("ld r4 retired", 32'(retired), 32'd3);
    check("ld r4 pc", 32'(bus.imem_addr), 32'd3);

    tick(); tick(); tick(); tick();                  // e12..e15
    check("pre-beq pc", 32'(bus.imem_addr), 32'd7);
    check("pre-beq retired", 32'(retired), 32'd6);
    tick();                                          // e16: BEQ taken
    check("beq target pc", 32'(bus.imem_addr), 32'd4);
    check("beq retired", 32'(retired), 32'd7);
    tick();                                          // e17: bubble
    check("bubble pc", 32'(bus.imem_addr), 32'd5);
    check("bubble retired", 32'(retired), 32'd7);
    tick(); tick(); tick();                          // e18..e20
    check("beq2 pc", 32'(bus.imem_addr), 32'd8);
    check("beq2 retired", 32'(retired), 32'd10);

    tick();                                          // e21: STORE r6
    check_req("st r6", 1'b1, 31, 8'h4A);
    check("st r6 pc", 32'(bus.imem_addr), 32'd8);
    bus.dmem_ack = 1'b1;
    tick();                                          // e22
    bus.dmem_ack = 1'b0;
    check("st r6 req low", {31'd0, bus.dmem_req}, 32'd0);
    check("st r6 retired", 32'(retired), 32'd11);
    tick();                                          // e23: fetch resumes
    check("st r6 fetch pc", 32'(bus.imem_addr), 32'd9);
    tick();                                          // e24: STORE r5
    check_req("st ovf", 1'b1, 7, 8'h01);
    bus.dmem_ack = 1'b1;
    tick();                                          // e25
    bus.dmem_ack = 1'b0;
    check("st ovf retired", 32'(retired), 32'd12);
    tick();                                          // e26
    tick();                                          // e27: STORE r0
    check_req("st r0", 1'b1, 6, 8'h00);
    bus.dmem_ack = 1'b1;
    tick();                                          // e28
    bus.dmem_ack = 1'b0;
    check("st r0 retired", 32'(retired), 32'd13);
    tick();                                          // e29: fetch HALT
    tick();                                          // e30: HALT executes
    check("halt flag", {31'd0, halted}, 32'd1);
    check("halt retired", 32'(retired), 32'd14);
    check("halt pc", 32'(bus.imem_addr), 32'd11);

    bus.dmem_ack = 1'b1;
    imem[11] = enc(OP_LOAD, 1, 0, 0, 2);
    for (int k = 0; k < 5; k++) tick();
    bus.dmem_ack = 1'b0;
    check("halted hold flag",    {31'd0, halted},       32'd1);
    check("halted hold pc",      32'(bus.imem_addr),    32'd11);
    check("halted hold retired", 32'(retired),          32'd14);
    check("halted hold req",     {31'd0, bus.dmem_req}, 32'd0);

    // ---------------- Phase C: asynchronous reset during MEM_WAIT
    rst_n = 1'b0;
    load_program();
    release_reset();
    tick();                                          // e1
    tick();                                          // e2: LOAD pending
    check("C req pending", {31'd0, bus.dmem_req}, 32'd1);
    check("C halted clear", {31'd0, halted}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("C async req", {31'd0, bus.dmem_req}, 32'd0);
    check("C async pc",  32'(bus.imem_addr),    32'd0);
    check("C async retired", 32'(retired),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
